// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted conditional branches awaiting resolution.
// Each accepted resolve emits one registered predictor update; a mispredict flushes the queue.
module branch_resolve_queue #(
   parameter int bit_width = 32,
   parameter int depth     = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   allocValid,
   input  logic [bit_width-1:0]   allocPc,
   input  logic                   allocPrediction,
   output logic                   allocReady,
   input  logic                   resolveValid,
   input  logic                   resolveTaken,
   output logic                   update,
   output logic [bit_width-1:0]   updatePc,
   output logic                   reality,
   output logic                   mispredict,
   output logic [$clog2(depth):0] count,
   output logic                   resolveError
);

   localparam int PTR_W = $clog2(depth);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [bit_width-1:0] pc;
      logic                 prediction;
   } entry_t;

   entry_t               mem_q [depth];

   logic [PTR_W-1:0]     head_q, head_d;
   logic [PTR_W-1:0]     tail_q, tail_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 update_q, update_d;
   logic [bit_width-1:0] update_pc_q, update_pc_d;
   logic                 reality_q, reality_d;
   logic                 mispredict_q, mispredict_d;
   logic                 resolve_error_q, resolve_error_d;

   entry_t               head_entry;
   logic                 push_ok;
   logic                 push_commit;
   logic                 resolve_ok;
   logic                 squash;

   // Ready depends only on the registered count, never on this cycle's resolve.
   assign allocReady = (count_q != CNT_W'(depth));

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      head_entry      = mem_q[head_q];
      push_ok         = allocValid && allocReady;
      resolve_ok      = resolveValid && (count_q != '0);
      squash          = resolve_ok && (head_entry.prediction != resolveTaken);
      push_commit     = push_ok && !squash;

      head_d          = head_q;
      tail_d          = tail_q;
      count_d         = count_q;
      update_d        = resolve_ok;
      mispredict_d    = squash;
      update_pc_d     = update_pc_q;
      reality_d       = reality_q;
      resolve_error_d = resolve_error_q | (resolveValid && (count_q == '0));

      if (resolve_ok) begin
         update_pc_d = head_entry.pc;
         reality_d   = resolveTaken;
      end

      // A mispredict discards every younger entry, including a same-cycle wrong-path push.
      if (squash) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (resolve_ok) begin
            head_d = head_q + PTR_W'(1);
         end
         if (push_commit) begin
            tail_d = tail_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push_commit) - CNT_W'(resolve_ok);
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (reset) begin
         head_q          <= '0;
         tail_q          <= '0;
         count_q         <= '0;
         update_q        <= 1'b0;
         update_pc_q     <= '0;
         reality_q       <= 1'b0;
         mispredict_q    <= 1'b0;
         resolve_error_q <= 1'b0;
      end else begin
         head_q          <= head_d;
         tail_q          <= tail_d;
         count_q         <= count_d;
         update_q        <= update_d;
         update_pc_q     <= update_pc_d;
         reality_q       <= reality_d;
         mispredict_q    <= mispredict_d;
         resolve_error_q <= resolve_error_d;
      end
   end

   // NOTE: entry storage is not reset; an entry is only read after a push has written it.
   always_ff @(posedge clk) begin
      if (!reset && push_commit) begin
         mem_q[tail_q] <= {allocPc, allocPrediction};
      end
   end

   assign update       = update_q;
   assign updatePc     = update_pc_q;
   assign reality      = reality_q;
   assign mispredict   = mispredict_q;
   assign count        = count_q;
   assign resolveError = resolve_error_q;

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

In-order queue of in-flight conditional-branch predictions, between fetch and the bimodal predictor's update port. Fetch pushes each predicted branch's PC and predicted direction; execute later resolves branches oldest-first with the actual direction. The block emits one registered update per resolution (PC plus actual outcome) to train the predictor. It flags a mispredict and squashes all younger queued entries when prediction and outcome differ.

## Interface
- bit_width, 32, PC width
- depth, 8, queue entries; power of two, minimum 2
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- allocValid  input  1  fetch pushes a predicted branch this cycle
- allocPc  input  bit_width  PC of the pushed branch
- allocPrediction  input  1  predicted direction (1 = taken)
- allocReady  output  1  queue not full; combinational from count
- resolveValid  input  1  execute resolves the oldest queued branch
- resolveTaken  input  1  actual direction of that branch
- update  output  1  registered one-cycle pulse: predictor update valid
- updatePc  output  bit_width  PC of the resolved branch
- reality  output  1  actual direction of the resolved branch
- mispredict  output  1  registered one-cycle pulse, coincident with update, when prediction differs from outcome
- count  output  $clog2(depth)+1  current number of queued entries
- resolveError  output  1  sticky; set by a resolve while empty

## Operation
- Storage: circular buffer of depth entries {pc, prediction}, with head (oldest) and tail pointers of $clog2(depth) bits that wrap modulo depth, and a separate count register.
- Push accepted iff allocValid && allocReady. Entry is written at tail, and tail increments.
- Resolve accepted iff resolveValid && count != 0. The head entry is read, head increments, and the next-cycle outputs are update=1, updatePc=entry.pc, reality=resolveTaken, mispredict=(entry.prediction != resolveTaken).
- Mispredict squash: on an accepted resolve with a mismatch, at the same edge head=tail=0 and count=0. Any push in that cycle is discarded as wrong-path.
- Simultaneous push and resolve (no mismatch): both take effect and count is unchanged. At full, allocReady=0 and the push is refused even if a resolve occurs in the same cycle.
- Resolve while empty: ignored. No update is emitted, resolveError is set, and it stays set until reset.
- When no resolve is accepted: update=0 and mispredict=0. updatePc and reality hold their last values.
- Reset (any cycle, including mid-operation): head=tail=count=0, update=0, mispredict=0, updatePc=0, reality=0, resolveError=0, allocReady=1. Entry contents need not be cleared.

## Timing
- Push at edge N: count reflects it after N. The entry is resolvable from cycle N+1.
- Resolve latency: resolve sampled at edge N, then update, updatePc, reality and mispredict are valid in cycle N..N+1 (one cycle, registered). Back-to-back resolves give back-to-back update pulses.
- Squash takes effect at the resolving edge. A resolve in the cycle right after a mispredicting resolve sees an empty queue, so resolveError is set.
- allocReady = (count != depth); it depends only on registered state.
- Arithmetic: count range is 0..depth. Pointers wrap with no extra bit.

## Test plan
- Reset, then push PCs 0x100 (pred 1), 0x104 (pred 0), then resolve taken, not-taken -> two update pulses: {0x100, reality 1, mispredict 0}, {0x104, reality 0, mispredict 0}; count returns to 0.
- Fill with depth=8 pushes -> allocReady=0 and count=8; a 9th push plus a simultaneous resolve -> 9th push refused, count=7; next cycle a push is accepted.
- Push 0x200 (pred 1), 0x204, 0x208, then resolve not-taken -> update {0x200, reality 0}, mispredict=1; count=0; a push in the resolving cycle is discarded.
- Resolve while empty -> no update, resolveError=1 and held; reset -> resolveError=0.
- Wrap-around: 20 alternating push/resolve pairs with PCs 0x0,0x4,… -> updates in push order, no loss or duplication across pointer wrap.
- Assert reset with 5 entries queued and a resolve pending -> next cycle update=0, count=0, allocReady=1.
